ecc_modarith_unit: RTL and testbench

ECC_MODARITH_UNIT -- requirements
Module: ecc_modarith_unit

---
 rtl/ecc_modarith_if.sv | 39 +++
 rtl/ecc_modarith_unit.sv | 137 +++++++++++++
 tb/tb_ecc_modarith_unit.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/ecc_modarith_if.sv
// Request/response bus for the modular-arithmetic unit.
// slave = the unit, master = whatever issues instructions to it.
interface ecc_modarith_if #(
    parameter int WIDTH    = 64,
    parameter int ID_WIDTH = 3
);
    logic                req_valid_i;
    logic                req_ready_o;
    logic [1:0]          req_op_i;
    logic [WIDTH-1:0]    req_a_i;
    logic [WIDTH-1:0]    req_b_i;
    logic [ID_WIDTH-1:0] req_id_i;
    logic [4:0]          req_rd_i;
    logic                kill_i;
    logic [ID_WIDTH-1:0] kill_id_i;
    logic                resp_valid_o;
    logic                resp_ready_i;
    logic [WIDTH-1:0]    resp_data_o;
    logic [ID_WIDTH-1:0] resp_id_o;
    logic [4:0]          resp_rd_o;
    logic                resp_we_o;
    logic                resp_err_o;
    logic [WIDTH-1:0]    modulo_o;
    logic                busy_o;

    modport slave (
        input  req_valid_i, req_op_i, req_a_i, req_b_i, req_id_i, req_rd_i,
        input  kill_i, kill_id_i, resp_ready_i,
        output req_ready_o, resp_valid_o, resp_data_o, resp_id_o, resp_rd_o,
        output resp_we_o, resp_err_o, modulo_o, busy_o
    );

    modport master (
        output req_valid_i, req_op_i, req_a_i, req_b_i, req_id_i, req_rd_i,
        output kill_i, kill_id_i, resp_ready_i,
        input  req_ready_o, resp_valid_o, resp_data_o, resp_id_o, resp_rd_o,
        input  resp_we_o, resp_err_o, modulo_o, busy_o
    );
endinterface

// File: rtl/ecc_modarith_unit.sv
// Modular add/sub unit with a programmable modulus; one instruction in flight,
// killable by id until its response is taken.
module ecc_modarith_unit #(
    parameter int WIDTH    = 64,
    parameter int ID_WIDTH = 3
) (
    input  logic           clk_i,
    input  logic           rst_i,
    ecc_modarith_if.slave  bus
);
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SET = 2'b10;
    localparam logic [1:0] OP_GET = 2'b11;

    typedef enum logic [1:0] {IDLE, COMPUTE, ADJUST, DONE} state_t;

    state_t              state_q;
    logic [1:0]          op_q;
    logic [WIDTH-1:0]    a_q, b_q, mod_q;
    logic [ID_WIDTH-1:0] id_q;
    logic [4:0]          rd_q;
    logic [WIDTH:0]      raw_q, raw_d;
    logic [WIDTH-1:0]    adj_d;
    logic                err_q;
    logic                kill_hit;
    logic                resp_valid_q, resp_we_q, resp_err_q;
    logic [WIDTH-1:0]    resp_data_q;
    logic [ID_WIDTH-1:0] resp_id_q;
    logic [4:0]          resp_rd_q;

    // raw_q[WIDTH] is the carry for ADD and the borrow (a < b) for SUB.
    always_comb begin
        raw_d = {1'b0, a_q} + {1'b0, b_q};
        if (op_q == OP_SUB)
            raw_d = {1'b0, a_q} - {1'b0, b_q};
        adj_d = raw_q[WIDTH-1:0];
        if (op_q == OP_ADD) begin
            if (raw_q >= {1'b0, mod_q})
                adj_d = raw_q[WIDTH-1:0] - mod_q;
        end else if (raw_q[WIDTH]) begin
            adj_d = raw_q[WIDTH-1:0] + mod_q;
        end
    end

    assign kill_hit = bus.kill_i && (bus.kill_id_i == id_q) && (state_q != IDLE);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            op_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            mod_q        <= '0;
            id_q         <= '0;
            rd_q         <= '0;
            raw_q        <= '0;
            err_q        <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_we_q    <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_rd_q    <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.req_valid_i) begin
                        op_q <= bus.req_op_i;
                        a_q  <= bus.req_a_i;
                        b_q  <= bus.req_b_i;
                        id_q <= bus.req_id_i;
                        rd_q <= bus.req_rd_i;
                        if (bus.req_op_i[1]) begin
                            state_q      <= DONE;
                            resp_valid_q <= 1'b1;
                            resp_id_q    <= bus.req_id_i;
                            resp_rd_q    <= bus.req_rd_i;
                            resp_we_q    <= (bus.req_op_i == OP_GET);
                            resp_err_q   <= 1'b0;
                            resp_data_q  <= (bus.req_op_i == OP_GET) ? mod_q : '0;
                        end else begin
                            state_q <= COMPUTE;
                        end
                    end
                end
                COMPUTE: begin
                    if (kill_hit) begin
                        state_q <= IDLE;
                    end else begin
                        raw_q   <= raw_d;
                        err_q   <= (mod_q == '0);
                        state_q <= ADJUST;
                    end
                end
                ADJUST: begin
                    if (kill_hit) begin
                        state_q <= IDLE;
                    end else begin
                        state_q      <= DONE;
                        resp_valid_q <= 1'b1;
                        resp_id_q    <= id_q;
                        resp_rd_q    <= rd_q;
                        resp_we_q    <= !err_q;
                        resp_err_q   <= err_q;
                        resp_data_q  <= err_q ? '0 : adj_d;
                    end
                end
                DONE: begin
                    // Kill wins over a same-cycle handshake, so no modulus write either.
                    if (kill_hit || bus.resp_ready_i) begin
                        if (!kill_hit && op_q == OP_SET)
                            mod_q <= a_q;
                        state_q      <= IDLE;
                        resp_valid_q <= 1'b0;
                        resp_we_q    <= 1'b0;
                        resp_err_q   <= 1'b0;
                        resp_data_q  <= '0;
                        resp_id_q    <= '0;
                        resp_rd_q    <= '0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready_o  = (state_q == IDLE);
    assign bus.busy_o       = (state_q != IDLE);
    assign bus.resp_valid_o = resp_valid_q;
    assign bus.resp_we_o    = resp_we_q;
    assign bus.resp_err_o   = resp_err_q;
    assign bus.resp_data_o  = resp_data_q;
    assign bus.resp_id_o    = resp_id_q;
    assign bus.resp_rd_o    = resp_rd_q;
    assign bus.modulo_o     = mod_q;
endmodule

// File: tb/tb_ecc_modarith_unit.sv
// Directed bench for ecc_modarith_unit: hand-computed vectors with p = 97,
// zero-modulus error, backpressure, kill and reset-abort cases.
module tb_ecc_modarith_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    always #5 clk = ~clk;

    ecc_modarith_if #(.WIDTH(64), .ID_WIDTH(3)) bus ();

    ecc_modarith_unit #(.WIDTH(64), .ID_WIDTH(3)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Presents one request for exactly one edge (the accept edge).
    task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [2:0] id, input logic [4:0] rd);
        bus.req_op_i    = op;
        bus.req_a_i     = a;
        bus.req_b_i     = b;
        bus.req_id_i    = id;
        bus.req_rd_i    = rd;
        bus.req_valid_i = 1'b1;
        step();
        bus.req_valid_i = 1'b0;
        bus.req_a_i     = '1;
        bus.req_b_i     = '1;
    endtask

    task automatic run_op(input string tag, input logic [1:0] op, input logic [63:0] a,
                          input logic [63:0] b, input logic [2:0] id, input logic [4:0] rd,
                          input logic [63:0] exp_data, input logic exp_we, input logic exp_err);
        issue(op, a, b, id, rd);
        if (!op[1]) begin
            chk({tag, "_compute_valid"}, 64'(bus.resp_valid_o), 64'd0);
            step();
            chk({tag, "_adjust_busy"}, 64'(bus.busy_o), 64'd1);
            step();
        end
        chk({tag, "_valid"}, 64'(bus.resp_valid_o), 64'd1);
        chk({tag, "_data"},  bus.resp_data_o, exp_data);
        chk({tag, "_id"},    64'(bus.resp_id_o), 64'(id));
        chk({tag, "_rd"},    64'(bus.resp_rd_o), 64'(rd));
        chk({tag, "_we"},    64'(bus.resp_we_o), 64'(exp_we));
        chk({tag, "_err"},   64'(bus.resp_err_o), 64'(exp_err));
        bus.resp_ready_i = 1'b1;
        step();
        bus.resp_ready_i = 1'b0;
        chk({tag, "_idle_valid"}, 64'(bus.resp_valid_o), 64'd0);
        chk({tag, "_idle_ready"}, 64'(bus.req_ready_o), 64'd1);
    endtask

    initial begin
        bus.req_valid_i  = 1'b0;
        bus.req_op_i     = 2'b00;
        bus.req_a_i      = '0;
        bus.req_b_i      = '0;
        bus.req_id_i     = '0;
        bus.req_rd_i     = '0;
        bus.kill_i       = 1'b0;
        bus.kill_id_i    = '0;
        bus.resp_ready_i = 1'b0;

        step();
        chk("rst_ready",  64'(bus.req_ready_o), 64'd1);
        chk("rst_busy",   64'(bus.busy_o), 64'd0);
        chk("rst_valid",  64'(bus.resp_valid_o), 64'd0);
        chk("rst_data",   bus.resp_data_o, 64'd0);
        chk("rst_modulo", bus.modulo_o, 64'd0);
        rst = 1'b0;
        step();
        chk("post_rst_ready", 64'(bus.req_ready_o), 64'd1);
        chk("post_rst_we",    64'(bus.resp_we_o), 64'd0);

        run_op("add_p0", 2'b00, 64'd1, 64'd2, 3'd1, 5'd3, 64'd0, 1'b0, 1'b1);

        // SET_MOD: modulus changes only on the response handshake.
        issue(2'b10, 64'd97, 64'd0, 3'd1, 5'd1);
        chk("setmod_valid",      64'(bus.resp_valid_o), 64'd1);
        chk("setmod_data",       bus.resp_data_o, 64'd0);
        chk("setmod_we",         64'(bus.resp_we_o), 64'd0);
        chk("setmod_pre_modulo", bus.modulo_o, 64'd0);
        bus.resp_ready_i = 1'b1;
        step();
        bus.resp_ready_i = 1'b0;
        chk("setmod_modulo", bus.modulo_o, 64'd97);

        run_op("add_50_60", 2'b00, 64'd50, 64'd60, 3'd2, 5'd5, 64'd13, 1'b1, 1'b0);
        chk("modulo_97", bus.modulo_o, 64'd97);
        run_op("sub_10_20", 2'b01, 64'd10, 64'd20, 3'd3, 5'd6, 64'd87, 1'b1, 1'b0);
        run_op("sub_20_10", 2'b01, 64'd20, 64'd10, 3'd4, 5'd7, 64'd10, 1'b1, 1'b0);
        run_op("add_96_0",  2'b00, 64'd96, 64'd0,  3'd5, 5'd8, 64'd96, 1'b1, 1'b0);
        run_op("add_96_1",  2'b00, 64'd96, 64'd1,  3'd6, 5'd9, 64'd0,  1'b1, 1'b0);
        run_op("sub_5_5",   2'b01, 64'd5,  64'd5,  3'd7, 5'd31, 64'd0, 1'b1, 1'b0);
        run_op("getmod",    2'b11, 64'd0,  64'd0,  3'd2, 5'd4, 64'd97, 1'b1, 1'b0);

        // Backpressure: hold ready low for 5 cycles in DONE.
        issue(2'b00, 64'd3, 64'd4, 3'd5, 5'd10);
        step();
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.resp_valid_o), 64'd1);
            chk("bp_data",  bus.resp_data_o, 64'd7);
            chk("bp_id",    64'(bus.resp_id_o), 64'd5);
            chk("bp_rd",    64'(bus.resp_rd_o), 64'd10);
            chk("bp_ready", 64'(bus.req_ready_o), 64'd0);
            step();
        end
        bus.resp_ready_i = 1'b1;
        step();
        bus.resp_ready_i = 1'b0;
        chk("bp_release_ready", 64'(bus.req_ready_o), 64'd1);
        chk("bp_release_busy",  64'(bus.busy_o), 64'd0);

        // Matching kill during ADJUST.
        issue(2'b00, 64'd10, 64'd20, 3'd3, 5'd2);
        step();
        bus.kill_i    = 1'b1;
        bus.kill_id_i = 3'd3;
        step();
        bus.kill_i    = 1'b0;
        chk("kill_adj_ready", 64'(bus.req_ready_o), 64'd1);
        chk("kill_adj_valid", 64'(bus.resp_valid_o), 64'd0);
        step();
        chk("kill_adj_later", 64'(bus.resp_valid_o), 64'd0);

        // Non-matching kill during COMPUTE is ignored.
        issue(2'b00, 64'd5, 64'd6, 3'd4, 5'd11);
        bus.kill_i    = 1'b1;
        bus.kill_id_i = 3'd2;
        step();
        bus.kill_i    = 1'b0;
        step();
        chk("nokill_valid", 64'(bus.resp_valid_o), 64'd1);
        chk("nokill_data",  bus.resp_data_o, 64'd11);
        bus.resp_ready_i = 1'b1;
        step();
        bus.resp_ready_i = 1'b0;

        // Kill beats a same-cycle handshake on SET_MOD: modulus stays 97.
        issue(2'b10, 64'd50, 64'd0, 3'd6, 5'd0);
        bus.kill_i       = 1'b1;
        bus.kill_id_i    = 3'd6;
        bus.resp_ready_i = 1'b1;
        step();
        bus.kill_i       = 1'b0;
        bus.resp_ready_i = 1'b0;
        chk("kill_set_modulo", bus.modulo_o, 64'd97);
        chk("kill_set_valid",  64'(bus.resp_valid_o), 64'd0);

        // Kill in IDLE does not cancel a same-cycle accept.
        bus.kill_i    = 1'b1;
        bus.kill_id_i = 3'd7;
        issue(2'b00, 64'd1, 64'd1, 3'd7, 5'd12);
        bus.kill_i    = 1'b0;
        chk("idle_kill_busy", 64'(bus.busy_o), 64'd1);
        step();
        step();
        chk("idle_kill_data", bus.resp_data_o, 64'd2);
        bus.resp_ready_i = 1'b1;
        step();
        bus.resp_ready_i = 1'b0;

        // Asynchronous reset during COMPUTE.
        issue(2'b00, 64'd1, 64'd2, 3'd1, 5'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ready",  64'(bus.req_ready_o), 64'd1);
        chk("arst_valid",  64'(bus.resp_valid_o), 64'd0);
        chk("arst_modulo", bus.modulo_o, 64'd0);
        step();
        rst = 1'b0;
        step();
        chk("arst_after_busy", 64'(bus.busy_o), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
